// File: rtl/bm_hit_detect_if.sv
// Pixel-pipeline overlap bus into the bomberman hit detector, plus its event/status outputs.
// The master drives the pixel stream; the slave (the detector) drives the hit/status signals.
interface bm_hit_detect_if;
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       bm_hb_on;
    logic       enemy_on;
    logic       exp_on;
    logic       gameover;
    logic       hit_tick;
    logic       hit_src;
    logic       invuln;
    logic       bm_blink;

    modport master (
        output p_tick, x, y, video_on, bm_hb_on, enemy_on, exp_on, gameover,
        input  hit_tick, hit_src, invuln, bm_blink
    );

    modport slave (
        input  p_tick, x, y, video_on, bm_hb_on, enemy_on, exp_on, gameover,
        output hit_tick, hit_src, invuln, bm_blink
    );
endinterface

// File: rtl/bm_hit_detect.sv
// Frame-based damage detector: accumulates hitbox/enemy/explosion overlap per frame, fires a
// one-clock hit event at frame end, then holds a frame-counted invulnerability/blink window.
module bm_hit_detect #(
    parameter int unsigned MIN_OVERLAP   = 4,
    parameter int unsigned INVULN_FRAMES = 180,
    parameter int unsigned BLINK_BIT     = 2
) (
    input  logic           clk,
    input  logic           reset,
    bm_hit_detect_if.slave bus
);

    localparam logic [7:0] MIN_OV    = 8'(MIN_OVERLAP);
    localparam logic [7:0] INV_LOAD  = 8'(INVULN_FRAMES);
    localparam logic [2:0] BLINK_IDX = 3'(BLINK_BIT);

    typedef enum logic {
        ST_ARMED  = 1'b0,
        ST_INVULN = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] ov_cnt_q, ov_cnt_d;
    logic [7:0] inv_cnt_q, inv_cnt_d;
    logic       exp_seen_q, exp_seen_d;
    logic       go_hold_q, go_hold_d;
    logic       hit_tick_q, hit_tick_d;
    logic       hit_src_q, hit_src_d;

    logic       ov_pix;
    logic       fe;
    logic       count_en;
    logic       hit;
    logic [7:0] eff;

    assign ov_pix = bus.p_tick & bus.video_on & bus.bm_hb_on & (bus.enemy_on | bus.exp_on);
    assign fe     = bus.p_tick & (bus.x == 10'd639) & (bus.y == 10'd479);

    // After gameover drops, the partial frame in flight is discarded; counting restarts at the next fe.
    assign count_en = (state_q == ST_ARMED) & ~bus.gameover & ~go_hold_q;

    // Saturating count including the current pixel, so the frame's last pixel takes part in the decision.
    assign eff = (ov_pix && (ov_cnt_q != 8'hFF)) ? ov_cnt_q + 8'd1 : ov_cnt_q;
    assign hit = count_en & fe & (eff >= MIN_OV);

    // NOTE: every signal assigned in this block gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ov_cnt_d   = ov_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        exp_seen_d = exp_seen_q;
        go_hold_d  = go_hold_q;
        hit_tick_d = 1'b0;
        hit_src_d  = hit_src_q;

        if (bus.gameover) begin
            go_hold_d = 1'b1;
        end else if (fe) begin
            go_hold_d = 1'b0;
        end

        if (!count_en || fe) begin
            ov_cnt_d   = 8'd0;
            exp_seen_d = 1'b0;
        end else begin
            ov_cnt_d = eff;
            if (ov_pix && bus.exp_on) begin
                exp_seen_d = 1'b1;
            end
        end

        case (state_q)
            ST_ARMED: begin
                if (hit) begin
                    state_d    = ST_INVULN;
                    inv_cnt_d  = INV_LOAD;
                    hit_tick_d = 1'b1;
                    hit_src_d  = exp_seen_q | bus.exp_on;
                end
            end
            ST_INVULN: begin
                if (fe) begin
                    if (inv_cnt_q == 8'd1) begin
                        state_d   = ST_ARMED;
                        inv_cnt_d = 8'd0;
                    end else begin
                        inv_cnt_d = inv_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_ARMED;
                inv_cnt_d = 8'd0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge
    // values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ARMED;
            ov_cnt_q   <= 8'd0;
            inv_cnt_q  <= 8'd0;
            exp_seen_q <= 1'b0;
            go_hold_q  <= 1'b0;
            hit_tick_q <= 1'b0;
            hit_src_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ov_cnt_q   <= ov_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            exp_seen_q <= exp_seen_d;
            go_hold_q  <= go_hold_d;
            hit_tick_q <= hit_tick_d;
            hit_src_q  <= hit_src_d;
        end
    end

    assign bus.hit_tick = hit_tick_q;
    assign bus.hit_src  = hit_src_q;
    assign bus.invuln   = (state_q == ST_INVULN);
    assign bus.bm_blink = (state_q == ST_ARMED) | inv_cnt_q[BLINK_IDX];

endmodule

// File: doc/bm_hit_detect.md
# bm_hit_detect

Frame-based damage detector for bomberman. Watches the per-pixel hitbox/enemy/explosion overlap signals from the pixel pipeline and accumulates overlapping pixels over one frame. At frame end it emits a single-cycle hit event to the lives/score logic. After a hit it enforces a frame-counted invulnerability window and drives a blink enable for the bomberman sprite.

## Interface
- `MIN_OVERLAP`, default 4: overlapping visible pixels per frame needed to register a hit; legal range 1..255.
- `INVULN_FRAMES`, default 180: number of frame ends the invulnerability window lasts (3 s at 60 Hz); legal range 1..255.
- `BLINK_BIT`, default 2: bit of the invulnerability counter that drives `bm_blink`; legal range 0..7.
- `clk  in  1`  system clock.
- `reset  in  1`  asynchronous, active-high.
- `p_tick  in  1`  pixel strobe from the VGA sync; `x`, `y`, and the `*_on` inputs are valid only when it is high.
- `x, y  in  10 each`  current pixel coordinate.
- `video_on  in  1`  visible-area flag.
- `bm_hb_on  in  1`  current pixel is inside bomberman's hitbox.
- `enemy_on  in  1`  current pixel is an enemy pixel.
- `exp_on  in  1`  current pixel is an explosion pixel.
- `gameover  in  1`  game-over flag from the lives logic.
- `hit_tick  out  1`  one-clock pulse when a hit is registered.
- `hit_src  out  1`  source of the last hit: 1 = explosion, 0 = enemy; held until the next hit.
- `invuln  out  1`  high while the invulnerability window is active.
- `bm_blink  out  1`  sprite draw enable: 1 = draw bomberman.

## Operation
- Overlap pixel: `p_tick & video_on & bm_hb_on & (enemy_on | exp_on)`.
- Frame end (`fe`): `p_tick & x==639 & y==479`.
- Overlap counter:
  - `ov_cnt` is 8 bits, saturates at 255.
  - Increments on each overlap pixel while in ARMED and `gameover` is low.
  - Cleared on every `fe`.
  - Held at 0 in INVULN or while `gameover` is high.
- Source flag: `exp_seen` is set by any overlap pixel with `exp_on` high. It is cleared together with `ov_cnt`.
- Effective count at `fe`: `eff = ov_cnt + (fe pixel is an overlap pixel)`, saturating. The last pixel of the frame counts.
- State ARMED:
  - Condition: `fe & eff >= MIN_OVERLAP & !gameover`.
  - Action: go to INVULN, load `inv_cnt = INVULN_FRAMES`, pulse `hit_tick`.
  - `hit_src` is loaded with `exp_seen` OR'd with the `fe` pixel's `exp_on`. Explosion wins when both sources overlapped in the same frame.
- State INVULN:
  - On each `fe`, `inv_cnt` decrements.
  - On a `fe` with `inv_cnt == 1`, go to ARMED and set `inv_cnt = 0`.
  - Overlaps are ignored throughout. The first frame counted after return is the one following that `fe`.
- Outputs:
  - `invuln` = (state == INVULN).
  - `bm_blink` = 1 in ARMED; `inv_cnt[BLINK_BIT]` in INVULN.
- `gameover` high:
  - No new hit is registered and `hit_tick` stays low.
  - An in-progress INVULN window runs to completion.
  - When `gameover` deasserts, counting resumes at the next `fe`.
- Reset values:
  - state ARMED, `ov_cnt` = 0, `exp_seen` = 0, `inv_cnt` = 0.
  - Outputs: `hit_tick` = 0, `hit_src` = 0, `invuln` = 0, `bm_blink` = 1.

## Timing
- All state is registered on the rising edge of `clk`. `reset` clears everything asynchronously.
- `hit_tick` is high for exactly one clock, the cycle after the `fe` clock edge. It never lasts more than one cycle, even though `x`/`y` are held for several clocks per pixel; only `p_tick` cycles are sampled.
- `invuln` rises in the same cycle as `hit_tick`.
- `invuln` falls in the cycle after the INVULN_FRAMES-th subsequent `fe`.
- Minimum spacing between two `hit_tick` pulses is INVULN_FRAMES+1 frames.
- `bm_blink` toggles every 2^BLINK_BIT frames during INVULN (default: every 4 frames).
- Reset asserted mid-INVULN returns to ARMED immediately with no pending `hit_tick`.
- Pixel inputs sampled when `p_tick` is low are ignored entirely.

## Test plan
- Enemy hit:
  - Stimulus: one frame with 10 overlap pixels, `enemy_on` only.
  - Required: `hit_tick` = 1 for exactly 1 clk after `fe`; `hit_src` = 0; `invuln` = 1.
- Threshold boundary, `MIN_OVERLAP` = 4:
  - Stimulus: one frame with 3 overlap pixels, then one frame with 4, the 4th being pixel (639,479).
  - Required: no hit after the first frame; `hit_tick` after the second.
- Invulnerability window, `INVULN_FRAMES` = 5:
  - Stimulus: a hit, then continuous overlap in every following frame.
  - Required: `invuln` high for 5 frame ends; `bm_blink` follows `inv_cnt[2]`; the next `hit_tick` comes at the end of the 6th frame after the hit.
- Mixed source:
  - Stimulus: the same frame contains 2 enemy overlap pixels and 3 explosion overlap pixels (`MIN_OVERLAP` = 4).
  - Required: hit registered; `hit_src` = 1.
- Gameover:
  - Stimulus: `gameover` = 1 with 100 overlap pixels per frame for 3 frames.
  - Required: `hit_tick` never asserts; `ov_cnt` stays 0; `bm_blink` = 1.
- Reset mid-window:
  - Stimulus: assert `reset` while `inv_cnt` = 3, then release.
  - Required: `invuln` = 0, `bm_blink` = 1, `hit_src` = 0 immediately; no `hit_tick`.
